// File: rtl/ibex_obi_arbiter.sv
// N-port Ibex/OBI requester arbiter onto a single device port, routing in-order responses back
// to the issuing port. Define COCOTB_IBEX_ARB_RR_EN for round-robin; default is fixed priority.
module ibex_obi_arbiter #(
  parameter int NumPorts       = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 4,
  localparam int BeW  = DataWidth / 8,
  localparam int IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  localparam int CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumPorts-1:0]           host_req_i,
  output logic [NumPorts-1:0]           host_gnt_o,
  output logic [NumPorts-1:0]           host_rvalid_o,
  input  logic [NumPorts-1:0]           host_we_i,
  input  logic [NumPorts*BeW-1:0]       host_be_i,
  input  logic [NumPorts*AddrWidth-1:0] host_addr_i,
  input  logic [NumPorts*DataWidth-1:0] host_wdata_i,
  output logic [DataWidth-1:0]          host_rdata_o,
  output logic                          dev_req_o,
  input  logic                          dev_gnt_i,
  input  logic                          dev_rvalid_i,
  output logic                          dev_we_o,
  output logic [BeW-1:0]                dev_be_o,
  output logic [AddrWidth-1:0]          dev_addr_o,
  output logic [DataWidth-1:0]          dev_wdata_o,
  input  logic [DataWidth-1:0]          dev_rdata_i,
  output logic [CntW-1:0]               outstanding_o,
  output logic                          err_o
);
  localparam int FpW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [FpW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] arb_idx, sel;
  logic            arb_found, full, empty, push, pop;

  function automatic logic [FpW-1:0] fifo_inc(input logic [FpW-1:0] p);
    return (p == FpW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);

`ifdef COCOTB_IBEX_ARB_RR_EN
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NumPorts-1:0] req_rot;
  logic [IdxW:0]       rr_k;

  // Rotate requests so bit 0 is the port the pointer names; first set bit wins.
  always_comb begin
    req_rot   = NumPorts'({host_req_i, host_req_i} >> rr_ptr_q);
    arb_idx   = '0;
    arb_found = 1'b0;
    rr_k      = '0;
    for (int i = 0; i < NumPorts; i++) begin
      rr_k = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      if (rr_k >= (IdxW+1)'(NumPorts)) rr_k = rr_k - (IdxW+1)'(NumPorts);
      if (!arb_found && req_rot[i]) begin
        arb_found = 1'b1;
        arb_idx   = rr_k[IdxW-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (sel == IdxW'(NumPorts - 1)) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int i = 0; i < NumPorts; i++) begin
      if (!arb_found && host_req_i[i]) begin
        arb_found = 1'b1;
        arb_idx   = IdxW'(i);
      end
    end
  end
`endif

  // A stalled request keeps the device port until it is granted.
  assign sel       = lock_q ? lock_idx_q : arb_idx;
  assign dev_req_o = (|host_req_i) & ~full;
  assign push      = dev_req_o & dev_gnt_i;
  assign pop       = dev_rvalid_i & ~empty;

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    dev_we_o      = 1'b0;
    dev_be_o      = '0;
    dev_addr_o    = '0;
    dev_wdata_o   = '0;
    if (dev_req_o) begin
      dev_we_o        = host_we_i[sel];
      dev_be_o        = host_be_i[int'(sel)*BeW +: BeW];
      dev_addr_o      = host_addr_i[int'(sel)*AddrWidth +: AddrWidth];
      dev_wdata_o     = host_wdata_i[int'(sel)*DataWidth +: DataWidth];
      host_gnt_o[sel] = dev_gnt_i;
    end
    if (pop) host_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
    host_rdata_o = dev_rvalid_i ? dev_rdata_i : '0;
  end

  always_comb begin
    wr_ptr_d   = push ? fifo_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? fifo_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d      = cnt_q + CntW'(push) - CntW'(pop);
    err_d      = err_q | (dev_rvalid_i & empty);
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (dev_req_o && !dev_gnt_i) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end else if (dev_gnt_i) begin
      lock_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
      if (push) fifo_q[wr_ptr_q] <= sel;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule
